// File: rtl/sv32_ptw.sv
// sv32_ptw -- Sv32 two-level page-table walker with optional one-entry TLB.
//
// Translates one virtual address at a time. Machine-mode requests bypass
// translation. Other requests read one or two PTEs from data memory, which
// returns read data combinationally in the same cycle as the address.
//
// Optional feature macro: PTW_TLB_EN
//   When this macro is defined, a one-entry TLB caches the last successful
//   translation. tlb_flush clears that entry. When the macro is undefined,
//   every translated request does a full walk and tlb_flush has no effect.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (req_ready only in IDLE)
//   req_vaddr, req_is_store    virtual address, access type (store needs W)
//   priv_m                     machine mode: paddr = vaddr, no walk
//   satp_ppn                   root page-table PPN (live value is used)
//   tlb_flush                  single-cycle TLB invalidate (sfence.vma)
//   mem_en, mem_addr           PTE read request (only in L1/L0, else 0)
//   mem_rdata                  PTE read data, same-cycle
//   resp_valid/resp_ready      response handshake
//   resp_paddr, resp_fault     physical address (0 on fault), page fault
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// L1    | reading the level-1 PTE (satp root table)
// L0    | reading the level-0 PTE (table from level-1 PTE)
// RESP  | holding the result until resp_ready
module sv32_ptw (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_vaddr,
    input  logic        req_is_store,
    input  logic        priv_m,
    input  logic [21:0] satp_ppn,
    input  logic        tlb_flush,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_paddr,
    output logic        resp_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_L1   = 2'd1,
        S_L0   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] va_q;
    logic        store_q;
    logic        priv_q;
    logic [19:0] pte1_ppn_q, pte1_ppn_d;
    logic [31:0] paddr_q, paddr_d;
    logic        fault_q, fault_d;
    logic        accept;
    logic        fill_en;
    logic        fill_super;

    // PTE decode of the word currently on mem_rdata.
    logic pte_v, pte_r, pte_w, pte_x;
    logic pte_invalid, pte_leaf, pte_perm_fault;

    assign pte_v          = mem_rdata[0];
    assign pte_r          = mem_rdata[1];
    assign pte_w          = mem_rdata[2];
    assign pte_x          = mem_rdata[3];
    // W without R is a reserved encoding and treated like V=0.
    assign pte_invalid    = !pte_v || (!pte_r && pte_w);
    assign pte_leaf       = pte_r || pte_x;
    assign pte_perm_fault = store_q ? !pte_w : !pte_r;

    assign accept = req_valid && req_ready;

    // TLB lookup is done against the live request so a hit can respond at T+1.
    logic        tlb_hit;
    logic        tlb_perm_fault;
    logic [31:0] tlb_paddr;

`ifdef PTW_TLB_EN
    logic        tlb_valid_q;
    logic [19:0] tlb_vpn_q;
    logic [19:0] tlb_ppn_q;
    logic        tlb_r_q;
    logic        tlb_w_q;
    logic        tlb_super_q;

    // A superpage entry covers 4 MiB, so only the upper VPN bits are compared.
    assign tlb_hit = tlb_valid_q &&
                     (tlb_super_q ? (tlb_vpn_q[19:10] == req_vaddr[31:22])
                                  : (tlb_vpn_q == req_vaddr[31:12]));
    assign tlb_perm_fault = req_is_store ? !tlb_w_q : !tlb_r_q;
    assign tlb_paddr = tlb_super_q ? {tlb_ppn_q[19:10], req_vaddr[21:0]}
                                   : {tlb_ppn_q, req_vaddr[11:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlb_valid_q <= 1'b0;
            tlb_vpn_q   <= 20'd0;
            tlb_ppn_q   <= 20'd0;
            tlb_r_q     <= 1'b0;
            tlb_w_q     <= 1'b0;
            tlb_super_q <= 1'b0;
        end else if (tlb_flush) begin
            // Flush takes priority over a fill landing in the same cycle.
            tlb_valid_q <= 1'b0;
        end else if (fill_en) begin
            tlb_valid_q <= 1'b1;
            tlb_vpn_q   <= va_q[31:12];
            tlb_ppn_q   <= mem_rdata[29:10];
            tlb_r_q     <= pte_r;
            tlb_w_q     <= pte_w;
            tlb_super_q <= fill_super;
        end
    end
`else
    assign tlb_hit        = 1'b0;
    assign tlb_perm_fault = 1'b0;
    assign tlb_paddr      = 32'h0;

    logic unused_tlb;
    assign unused_tlb = ^{tlb_flush, fill_en, fill_super};
`endif

    // PTE software bits, physical bits above 32-bit PA, and the registered
    // privilege (the bypass decision is made at accept) are not needed.
    logic unused_bits;
    assign unused_bits = ^{mem_rdata[31:30], mem_rdata[9:4], satp_ppn[21:20], priv_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            va_q       <= 32'h0;
            store_q    <= 1'b0;
            priv_q     <= 1'b0;
            pte1_ppn_q <= 20'd0;
            paddr_q    <= 32'h0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pte1_ppn_q <= pte1_ppn_d;
            paddr_q    <= paddr_d;
            fault_q    <= fault_d;
            if (accept) begin
                va_q    <= req_vaddr;
                store_q <= req_is_store;
                priv_q  <= priv_m;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pte1_ppn_d = pte1_ppn_q;
        paddr_d    = paddr_q;
        fault_d    = fault_q;
        fill_en    = 1'b0;
        fill_super = 1'b0;
        req_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = 32'h0;
        resp_valid = 1'b0;
        resp_paddr = 32'h0;
        resp_fault = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (priv_m) begin
                        state_d = S_RESP;
                        paddr_d = req_vaddr;
                        fault_d = 1'b0;
                    end else if (tlb_hit) begin
                        state_d = S_RESP;
                        fault_d = tlb_perm_fault;
                        paddr_d = tlb_perm_fault ? 32'h0 : tlb_paddr;
                    end else begin
                        state_d = S_L1;
                    end
                end
            end

            S_L1: begin
                mem_en   = 1'b1;
                mem_addr = {satp_ppn[19:0], 12'h000} + {20'd0, va_q[31:22], 2'b00};
                if (!pte_invalid && !pte_leaf) begin
                    state_d    = S_L0;
                    pte1_ppn_d = mem_rdata[29:10];
                end else begin
                    state_d = S_RESP;
                    fault_d = 1'b1;
                    paddr_d = 32'h0;
                    // Superpage leaf must be 4 MiB aligned (PPN[0] field zero).
                    if (!pte_invalid && !pte_perm_fault && (mem_rdata[19:10] == 10'd0)) begin
                        fault_d    = 1'b0;
                        paddr_d    = {mem_rdata[29:20], va_q[21:0]};
                        fill_en    = 1'b1;
                        fill_super = 1'b1;
                    end
                end
            end

            S_L0: begin
                mem_en   = 1'b1;
                mem_addr = {pte1_ppn_q, 12'h000} + {20'd0, va_q[21:12], 2'b00};
                state_d  = S_RESP;
                fault_d  = 1'b1;
                paddr_d  = 32'h0;
                if (!pte_invalid && pte_leaf && !pte_perm_fault) begin
                    fault_d = 1'b0;
                    paddr_d = {mem_rdata[29:10], va_q[11:0]};
                    fill_en = 1'b1;
                end
            end

            S_RESP: begin
                resp_valid = 1'b1;
                resp_paddr = paddr_q;
                resp_fault = fault_q;
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
